sfx_tone_sequencer: RTL and testbench



---
 rtl/sfx_tone_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sfx_tone_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_tone_sequencer.sv
// sfx_tone_sequencer
// One sound-effect voice. While the active-low request `off_i` is held low the
// voice walks a fixed note table, producing a square wave for each note; a zero
// half-period entry is a rest. LOOP selects a repeating jingle (siren) or a
// one-shot jingle that must see the request released before it can replay.
// Every output comes straight from a flop.
module sfx_tone_sequencer #(
    parameter int unsigned                NUM_NOTES    = 4,
    parameter int unsigned                HP_W         = 16,
    parameter int unsigned                DUR_W        = 20,
    parameter int unsigned                NOTE_LEN     = 500000,
    parameter logic [NUM_NOTES*HP_W-1:0]  HALF_PERIODS = {16'd2, 16'd0, 16'd3, 16'd1},
    parameter bit                         LOOP         = 1'b0,
    localparam int unsigned               IDX_W        = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             off_i,
    input  logic             pause_i,
    output logic             wave_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] note_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Last duration count of a note and index of the final table entry.
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);

    // Entry 0 sits in the most significant slice of HALF_PERIODS, so the table
    // reads left-to-right in the same order as it is written in the parameter.
    function automatic logic [HP_W-1:0] half_of(input logic [IDX_W-1:0] idx);
        logic [HP_W-1:0] h;
        h = '0;
        for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            if (idx == IDX_W'(i)) begin
                h = HALF_PERIODS[(NUM_NOTES - 1 - i) * HP_W +: HP_W];
            end
        end
        return h;
    endfunction

    state_e             state_q,    state_d;
    logic [DUR_W-1:0]   dur_cnt_q,  dur_cnt_d;
    logic [HP_W-1:0]    tone_cnt_q, tone_cnt_d;
    logic [IDX_W-1:0]   note_idx_q, note_idx_d;
    logic               wave_q,     wave_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic [HP_W-1:0]    half_s;
    logic               note_end_s;
    logic               last_note_s;
    logic               advance_s;

    // Per-note decode of the current table entry and note position.
    always_comb begin
        half_s      = half_of(note_idx_q);
        note_end_s  = (dur_cnt_q == DUR_LAST);
        last_note_s = (note_idx_q == IDX_LAST);
        advance_s   = (state_q == ST_PLAY) && !pause_i;
    end

    // Next-state, counter and output computation for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        note_idx_d = note_idx_q;
        wave_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dur_cnt_d  = '0;
                tone_cnt_d = '0;
                note_idx_d = '0;
                if (!off_i && !pause_i) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PLAY: begin
                if (LOOP && off_i) begin
                    // A looping voice stops as soon as its request drops,
                    // even on the last cycle of a note.
                    state_d    = ST_IDLE;
                    dur_cnt_d  = '0;
                    tone_cnt_d = '0;
                    note_idx_d = '0;
                end else if (pause_i) begin
                    // Counters freeze; the wave restarts low on resume.
                    state_d = ST_PLAY;
                end else if (note_end_s) begin
                    // Note boundary beats any tone toggle due this cycle.
                    dur_cnt_d  = '0;
                    tone_cnt_d = '0;
                    if (!last_note_s) begin
                        state_d    = ST_PLAY;
                        note_idx_d = note_idx_q + IDX_W'(1);
                    end else if (LOOP) begin
                        state_d    = ST_PLAY;
                        note_idx_d = '0;
                    end else begin
                        state_d    = ST_HOLD;
                        note_idx_d = '0;
                    end
                end else begin
                    state_d   = ST_PLAY;
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    if (half_s == '0) begin
                        tone_cnt_d = '0;
                        wave_d     = 1'b0;
                    end else if (tone_cnt_q == (half_s - HP_W'(1))) begin
                        tone_cnt_d = '0;
                        wave_d     = ~wave_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + HP_W'(1);
                        wave_d     = wave_q;
                    end
                end
            end

            ST_HOLD: begin
                dur_cnt_d  = '0;
                tone_cnt_d = '0;
                note_idx_d = '0;
                // Only a released request re-arms a finished one-shot.
                if (off_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                dur_cnt_d  = '0;
                tone_cnt_d = '0;
                note_idx_d = '0;
            end
        endcase

        busy_d = (state_d == ST_PLAY);

        // done is a flop, so it is raised on the edge that moves the voice into
        // the final cycle of the final note; it is then high during exactly the
        // cycle whose closing edge finishes the sequence. A paused cycle never
        // re-raises it, keeping it a single-cycle pulse.
        done_d = (LOOP == 1'b0)
              && (state_d == ST_PLAY)
              && (dur_cnt_d == DUR_LAST)
              && (note_idx_d == IDX_LAST)
              && ((state_q != ST_PLAY) || advance_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            note_idx_q <= '0;
            wave_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            note_idx_q <= note_idx_d;
            wave_q     <= wave_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wave_o     = wave_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign note_idx_o = note_idx_q;

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Directed bench for sfx_tone_sequencer: a one-shot and a looping instance
// share a clock. Expected per-cycle outputs are pushed into a scoreboard queue
// as each input step is driven and popped when the cycle is observed.
module tb_sfx_tone_sequencer;

    localparam int NN = 4;
    localparam int NL = 8;
    localparam logic [63:0] HP = {16'd2, 16'd0, 16'd3, 16'd1};

    logic       clk = 1'b0;
    logic       reset;
    logic       off_a, pause_a, off_b, pause_b;
    logic       wave_a, busy_a, done_a;
    logic       wave_b, busy_b, done_b;
    logic [1:0] idx_a, idx_b;

    sfx_tone_sequencer #(
        .NUM_NOTES(NN), .HP_W(16), .DUR_W(20), .NOTE_LEN(NL),
        .HALF_PERIODS(HP), .LOOP(1'b0)
    ) u_once (
        .clk_i(clk), .reset_i(reset), .off_i(off_a), .pause_i(pause_a),
        .wave_o(wave_a), .busy_o(busy_a), .done_o(done_a), .note_idx_o(idx_a)
    );

    sfx_tone_sequencer #(
        .NUM_NOTES(NN), .HP_W(16), .DUR_W(20), .NOTE_LEN(NL),
        .HALF_PERIODS(HP), .LOOP(1'b1)
    ) u_loop (
        .clk_i(clk), .reset_i(reset), .off_i(off_b), .pause_i(pause_b),
        .wave_o(wave_b), .busy_o(busy_b), .done_o(done_b), .note_idx_o(idx_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wave;
        logic       wchk;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } exp_t;

    exp_t  sb_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    sel      = 1'b0;
    string phase    = "reset";
    int    hp_tab[4] = '{2, 0, 3, 1};

    // Expected outputs t cycles into uninterrupted playback (note = t / NOTE_LEN).
    function automatic exp_t play_exp(input int t, input logic dn);
        exp_t e;
        int n, p, h;
        n = (t / NL) % NN;
        p = t % NL;
        h = hp_tab[n];
        e.wave = (h == 0) ? 1'b0 : (((p / h) % 2) == 1);
        e.wchk = 1'b1;
        e.busy = 1'b1;
        e.done = dn;
        e.idx  = 2'(n);
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.wave = 1'b0;
        e.wchk = 1'b1;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.idx  = 2'd0;
        return e;
    endfunction

    task automatic cmp(input string name, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s cyc=%0d observed=%0d expected=%0d", phase, name, cyc, obs, exp);
        end
    endtask

    // Advance one clock, then pop the expected entry and compare it.
    task automatic step();
        exp_t e;
        logic w, b, d;
        logic [1:0] ix;
        @(posedge clk);
        #1;
        cyc++;
        w  = sel ? wave_b : wave_a;
        b  = sel ? busy_b : busy_a;
        d  = sel ? done_b : done_a;
        ix = sel ? idx_b  : idx_a;
        if (sb_q.size() == 0) begin
            cmp("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            if (e.wchk) begin
                cmp("wave", int'(w), int'(e.wave));
            end
            cmp("busy", int'(b), int'(e.busy));
            cmp("done", int'(d), int'(e.done));
            cmp("note_idx", int'(ix), int'(e.idx));
        end
    endtask

    initial begin
        exp_t e;
        int   te;

        reset   = 1'b1;
        off_a   = 1'b1; pause_a = 1'b0;
        off_b   = 1'b1; pause_b = 1'b0;

        // Reset state of both instances.
        sel = 1'b0; sb_q.push_back(idle_exp()); step();
        sel = 1'b1; sb_q.push_back(idle_exp()); step();
        reset = 1'b0;
        sel = 1'b0; sb_q.push_back(idle_exp()); step();

        // One-shot playback with the request held low.
        phase = "oneshot";
        off_a = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            cyc = k - 1;
            sb_q.push_back(play_exp(k - 1, k == 32));
            step();
        end

        // Held request after completion must not replay.
        phase = "hold";
        for (int k = 0; k < 20; k++) begin
            sb_q.push_back(idle_exp());
            step();
        end
        phase = "rearm";
        off_a = 1'b1;
        sb_q.push_back(idle_exp()); step();
        off_a = 1'b0;
        cyc = 0;
        sb_q.push_back(play_exp(0, 1'b0)); step();

        // Release mid-play is ignored by the one-shot.
        phase = "oneshot_release";
        for (int k = 2; k <= 32; k++) begin
            if (k == 6) off_a = 1'b1;
            sb_q.push_back(play_exp(k - 1, k == 32));
            step();
        end
        sb_q.push_back(idle_exp()); step();
        sb_q.push_back(idle_exp()); step();

        // Pause while idle holds off the start.
        phase = "idle_pause";
        pause_a = 1'b1;
        off_a   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(idle_exp());
            step();
        end
        pause_a = 1'b0;
        cyc = 0;
        sb_q.push_back(play_exp(0, 1'b0)); step();

        // Five-cycle pause starting in play cycle 4.
        phase = "pause";
        for (int k = 2; k <= 37; k++) begin
            pause_a = (k >= 5 && k <= 9);
            if (k <= 4)      te = k - 1;
            else if (k <= 9) te = 3;
            else             te = k - 6;
            e = play_exp(te, k == 37);
            if (k >= 5 && k <= 9) begin
                e.wave = 1'b0;
            end else if (k >= 10 && k <= 13) begin
                e.wchk = 1'b0;
            end else begin
                e.wchk = 1'b1;
            end
            sb_q.push_back(e);
            step();
        end
        pause_a = 1'b0;
        off_a   = 1'b1;
        sb_q.push_back(idle_exp()); step();
        sb_q.push_back(idle_exp()); step();

        // Synchronous reset during play cycle 10, request held low.
        phase = "reset_mid";
        off_a = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            sb_q.push_back(play_exp(k - 1, 1'b0));
            step();
        end
        reset = 1'b1;
        sb_q.push_back(idle_exp()); step();
        reset = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 32; k++) begin
            sb_q.push_back(play_exp(k - 1, k == 32));
            step();
        end
        off_a = 1'b1;
        sb_q.push_back(idle_exp()); step();
        sb_q.push_back(idle_exp()); step();

        // Looping instance: wraps, never pulses done, stops on release.
        phase = "loop";
        sel   = 1'b1;
        off_b = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            sb_q.push_back(play_exp(k - 1, 1'b0));
            step();
        end
        // Release lands on a note boundary; release wins.
        off_b = 1'b1;
        sb_q.push_back(idle_exp()); step();
        sb_q.push_back(idle_exp()); step();

        phase = "end";
        cmp("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
